// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU datapath.
// It also drives the shared memory port's request and times out stalled transfers.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             reg1_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [2:0]       alu_com,
  output logic             alu_src,
  output logic             reg2_sel,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd10;
  localparam logic [3:0] OP_STORE = 4'd11;
  localparam logic [3:0] OP_BR    = 4'd12;
  localparam logic [3:0] OP_NOP13 = 4'd13;
  localparam logic [3:0] OP_NOP14 = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_HALT,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic [2:0] alu_com;
    logic       alu_src;
    logic       reg2_sel;
    logic       reg_we;
    logic       wb_sel;
    logic       halted;
    logic       err;
  } ctrl_t;

  state_t            state_reg, state_next;
  logic [3:0]        op_reg, op_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]  retired_reg;
  logic              retire;
  ctrl_t             ctrl_dec, ctrl;

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    wait_cnt_next = wait_cnt_reg;
    retire        = 1'b0;

    case (state_reg)
      S_FETCH: begin
        if (mem_ack) begin
          state_next = S_DECODE;
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          state_next = S_ERROR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      S_DECODE: begin
        op_next = opcode;
        case (opcode)
          OP_NOP, OP_NOP13, OP_NOP14: begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
          OP_HALT: state_next = S_HALT;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        state_next = ((op_reg == OP_LOAD) || (op_reg == OP_STORE)) ? S_MEM : S_WB;
      end

      S_MEM: begin
        if (mem_ack) begin
          if (op_reg == OP_STORE) begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          state_next = S_ERROR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      S_WB, S_BRANCH: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end

      S_HALT:  state_next = S_HALT;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_ERROR;
    endcase

    // Every memory phase starts with a fresh timeout window.
    if ((state_next != state_reg) && ((state_next == S_FETCH) || (state_next == S_MEM))) begin
      wait_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      op_reg       <= 4'd0;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      wait_cnt_reg <= wait_cnt_next;
      if (retire) begin
        retired_reg <= retired_reg + 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_dec = '0;
    case (state_reg)
      S_FETCH: begin
        ctrl_dec.mem_req = 1'b1;
        if (mem_ack) begin
          ctrl_dec.ir_we = 1'b1;
          ctrl_dec.pc_we = 1'b1;
        end
      end

      S_EXEC: begin
        if ((op_reg >= 4'd1) && (op_reg <= 4'd8)) begin
          ctrl_dec.alu_com = 3'(op_reg - 4'd1);
        end
        ctrl_dec.alu_src = (op_reg >= 4'd9) && (op_reg <= OP_STORE);
      end

      S_MEM: begin
        ctrl_dec.mem_req      = 1'b1;
        ctrl_dec.mem_addr_sel = 1'b1;
        ctrl_dec.alu_src      = 1'b1;
        if (op_reg == OP_STORE) begin
          ctrl_dec.mem_we   = 1'b1;
          ctrl_dec.reg2_sel = 1'b1;
        end
      end

      S_WB: begin
        ctrl_dec.reg_we = 1'b1;
        ctrl_dec.wb_sel = (op_reg != OP_LOAD);
      end

      S_BRANCH: begin
        ctrl_dec.pc_src = 1'b1;
        ctrl_dec.pc_we  = reg1_zero;
      end

      S_HALT:  ctrl_dec.halted = 1'b1;
      S_ERROR: ctrl_dec.err    = 1'b1;
      default: ctrl_dec = '0;
    endcase
  end

  // The reset state is FETCH, but nothing may be requested while reset is held.
  assign ctrl = rst_n ? ctrl_dec : '0;

  assign mem_req      = ctrl.mem_req;
  assign mem_we       = ctrl.mem_we;
  assign mem_addr_sel = ctrl.mem_addr_sel;
  assign ir_we        = ctrl.ir_we;
  assign pc_we        = ctrl.pc_we;
  assign pc_src       = ctrl.pc_src;
  assign alu_com      = ctrl.alu_com;
  assign alu_src      = ctrl.alu_src;
  assign reg2_sel     = ctrl.reg2_sel;
  assign reg_we       = ctrl.reg_we;
  assign wb_sel       = ctrl.wb_sel;
  assign halted       = ctrl.halted;
  assign err          = ctrl.err;
  assign retired      = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle strobe vectors and retire counts
// for each instruction class, memory wait/timeout edges and asynchronous reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        reg1_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
  logic [2:0]  alu_com;
  logic        alu_src, reg2_sel, reg_we, wb_sel, halted, err;
  logic [15:0] retired;
  logic [14:0] strb;

  int vectors = 0;
  int miscompares = 0;

  // Bit order: req we asel irwe pcwe pcsrc alu[2:0] asrc r2sel regwe wbsel halted err
  localparam logic [14:0] V_ZERO   = 15'b0_0_0_0_0_0_000_0_0_0_0_0_0;
  localparam logic [14:0] V_FW     = 15'b1_0_0_0_0_0_000_0_0_0_0_0_0;
  localparam logic [14:0] V_FA     = 15'b1_0_0_1_1_0_000_0_0_0_0_0_0;
  localparam logic [14:0] V_EX5    = 15'b0_0_0_0_0_0_100_0_0_0_0_0_0;
  localparam logic [14:0] V_EX_IMM = 15'b0_0_0_0_0_0_000_1_0_0_0_0_0;
  localparam logic [14:0] V_MEM_L  = 15'b1_0_1_0_0_0_000_1_0_0_0_0_0;
  localparam logic [14:0] V_MEM_S  = 15'b1_1_1_0_0_0_000_1_1_0_0_0_0;
  localparam logic [14:0] V_WB_ALU = 15'b0_0_0_0_0_0_000_0_0_1_1_0_0;
  localparam logic [14:0] V_WB_LD  = 15'b0_0_0_0_0_0_000_0_0_1_0_0_0;
  localparam logic [14:0] V_BR_T   = 15'b0_0_0_0_1_1_000_0_0_0_0_0_0;
  localparam logic [14:0] V_BR_N   = 15'b0_0_0_0_0_1_000_0_0_0_0_0_0;
  localparam logic [14:0] V_HALT   = 15'b0_0_0_0_0_0_000_0_0_0_0_1_0;
  localparam logic [14:0] V_ERR    = 15'b0_0_0_0_0_0_000_0_0_0_0_0_1;

  assign strb = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_com,
                 alu_src, reg2_sel, reg_we, wb_sel, halted, err};

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .reg1_zero(reg1_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_com(alu_com), .alu_src(alu_src),
    .reg2_sel(reg2_sel), .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted), .err(err),
    .retired(retired)
  );

  task automatic test_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ack = 1'b0;
    #1;
    vectors++;
    if (strb !== V_ZERO) begin
      miscompares++;
      $display("FAIL %s strobes: got %b expected %b", tag, strb, V_ZERO);
    end
    vectors++;
    if (retired !== 16'd0) begin
      miscompares++;
      $display("FAIL %s retired: got %0d expected 0", tag, retired);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    $display("reset %s: strobes %b retired %0d", tag, strb, retired);
  endtask

  task automatic test_alu();
    logic [14:0] e1 [4] = '{V_FA, V_ZERO, V_ZERO, V_WB_ALU};
    logic [14:0] e5 [5] = '{V_FW, V_FA, V_ZERO, V_EX5, V_WB_ALU};
    logic [0:4]  a5 = 5'b01111;
    logic [14:0] e9 [4] = '{V_FA, V_ZERO, V_EX_IMM, V_WB_ALU};
    opcode = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      vectors++;
      if (strb !== e1[i]) begin
        miscompares++;
        $display("FAIL alu_op1 cycle %0d: got %b expected %b", i, strb, e1[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd1) begin
      miscompares++;
      $display("FAIL alu_op1 retired: got %0d expected 1", retired);
    end
    $display("op1 done: retired %0d", retired);
    opcode = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ack = a5[i]; #1;
      vectors++;
      if (strb !== e5[i]) begin
        miscompares++;
        $display("FAIL alu_op5 cycle %0d: got %b expected %b", i, strb, e5[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd2) begin
      miscompares++;
      $display("FAIL alu_op5 retired: got %0d expected 2", retired);
    end
    $display("op5 done: retired %0d", retired);
    opcode = 4'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      vectors++;
      if (strb !== e9[i]) begin
        miscompares++;
        $display("FAIL alu_op9 cycle %0d: got %b expected %b", i, strb, e9[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd3) begin
      miscompares++;
      $display("FAIL alu_op9 retired: got %0d expected 3", retired);
    end
    $display("op9 done: retired %0d", retired);
  endtask

  task automatic test_load();
    logic [14:0] e [8] = '{V_FA, V_ZERO, V_EX_IMM, V_MEM_L, V_MEM_L, V_MEM_L, V_MEM_L, V_WB_LD};
    logic [0:7]  a = 8'b1110_0011;
    opcode = 4'd10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mem_ack = a[i]; #1;
      vectors++;
      if (strb !== e[i]) begin
        miscompares++;
        $display("FAIL load cycle %0d: got %b expected %b", i, strb, e[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd4) begin
      miscompares++;
      $display("FAIL load retired: got %0d expected 4", retired);
    end
    $display("load done: retired %0d", retired);
  endtask

  task automatic test_store();
    logic [14:0] e [4] = '{V_FA, V_ZERO, V_EX_IMM, V_MEM_S};
    opcode = 4'd11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      vectors++;
      if (strb !== e[i]) begin
        miscompares++;
        $display("FAIL store cycle %0d: got %b expected %b", i, strb, e[i]);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; #1;
    vectors++;
    if (strb !== V_FW) begin
      miscompares++;
      $display("FAIL store next_fetch: got %b expected %b", strb, V_FW);
    end
    vectors++;
    if (retired !== 16'd5) begin
      miscompares++;
      $display("FAIL store retired: got %0d expected 5", retired);
    end
    $display("store done: retired %0d", retired);
  endtask

  task automatic test_branch();
    logic [14:0] et [3] = '{V_FA, V_ZERO, V_BR_T};
    logic [14:0] en [3] = '{V_FA, V_ZERO, V_BR_N};
    opcode = 4'd12;
    reg1_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      vectors++;
      if (strb !== et[i]) begin
        miscompares++;
        $display("FAIL branch_taken cycle %0d: got %b expected %b", i, strb, et[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd6) begin
      miscompares++;
      $display("FAIL branch_taken retired: got %0d expected 6", retired);
    end
    $display("branch taken done: retired %0d", retired);
    reg1_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      vectors++;
      if (strb !== en[i]) begin
        miscompares++;
        $display("FAIL branch_not_taken cycle %0d: got %b expected %b", i, strb, en[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd7) begin
      miscompares++;
      $display("FAIL branch_not_taken retired: got %0d expected 7", retired);
    end
    $display("branch not taken done: retired %0d", retired);
  endtask

  task automatic test_nop();
    logic [14:0] e [2] = '{V_FA, V_ZERO};
    logic [14:0] ew [5] = '{V_FW, V_FW, V_FW, V_FA, V_ZERO};
    logic [0:4]  aw = 5'b00011;
    opcode = 4'd14;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      vectors++;
      if (strb !== e[i]) begin
        miscompares++;
        $display("FAIL nop cycle %0d: got %b expected %b", i, strb, e[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd8) begin
      miscompares++;
      $display("FAIL nop retired: got %0d expected 8", retired);
    end
    $display("nop done: retired %0d", retired);
    // Fetch ack lands exactly in the limit cycle and must win over the timeout.
    opcode = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ack = aw[i]; #1;
      vectors++;
      if (strb !== ew[i]) begin
        miscompares++;
        $display("FAIL ack_at_limit cycle %0d: got %b expected %b", i, strb, ew[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd9) begin
      miscompares++;
      $display("FAIL ack_at_limit retired: got %0d expected 9", retired);
    end
    $display("ack at limit done: retired %0d", retired);
  endtask

  task automatic test_timeout();
    logic [14:0] e [7] = '{V_FW, V_FW, V_FW, V_FW, V_ERR, V_ERR, V_ERR};
    logic [0:6]  a = 7'b0000010;
    opcode = 4'd1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); mem_ack = a[i]; #1;
      vectors++;
      if (strb !== e[i]) begin
        miscompares++;
        $display("FAIL timeout cycle %0d: got %b expected %b", i, strb, e[i]);
      end
    end
    vectors++;
    if (retired !== 16'd9) begin
      miscompares++;
      $display("FAIL timeout retired: got %0d expected 9", retired);
    end
    $display("timeout done: err %b retired %0d", err, retired);
  endtask

  task automatic test_halt();
    logic [14:0] e [5] = '{V_FA, V_ZERO, V_HALT, V_HALT, V_HALT};
    logic [0:4]  a = 5'b11110;
    opcode = 4'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ack = a[i]; #1;
      vectors++;
      if (strb !== e[i]) begin
        miscompares++;
        $display("FAIL halt cycle %0d: got %b expected %b", i, strb, e[i]);
      end
    end
    vectors++;
    if (retired !== 16'd0) begin
      miscompares++;
      $display("FAIL halt retired: got %0d expected 0", retired);
    end
    $display("halt done: halted %b retired %0d", halted, retired);
  endtask

  task automatic test_reset_mid_mem();
    logic [14:0] e [6] = '{V_FA, V_ZERO, V_FA, V_ZERO, V_EX_IMM, V_MEM_L};
    logic [0:5]  a = 6'b111110;
    logic [3:0]  o [6] = '{4'd13, 4'd13, 4'd10, 4'd10, 4'd10, 4'd10};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ack = a[i]; opcode = o[i]; #1;
      vectors++;
      if (strb !== e[i]) begin
        miscompares++;
        $display("FAIL mid_mem cycle %0d: got %b expected %b", i, strb, e[i]);
      end
    end
    vectors++;
    if (retired !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_mem pre-reset retired: got %0d expected 1", retired);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (strb !== V_ZERO) begin
      miscompares++;
      $display("FAIL mid_mem async reset strobes: got %b expected %b", strb, V_ZERO);
    end
    vectors++;
    if (retired !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_mem async reset retired: got %0d expected 0", retired);
    end
    $display("reset mid-MEM: strobes %b retired %0d", strb, retired);
    @(posedge clk);
    #2 rst_n = 1'b1;
    opcode = 4'd13;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      vectors++;
      if (strb !== e[i]) begin
        miscompares++;
        $display("FAIL post_reset cycle %0d: got %b expected %b", i, strb, e[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (retired !== 16'd1) begin
      miscompares++;
      $display("FAIL post_reset retired: got %0d expected 1", retired);
    end
    $display("post-reset nop done: retired %0d", retired);
  endtask

  initial begin
    test_reset("initial");
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_nop();
    test_timeout();
    test_reset("after_error");
    test_halt();
    test_reset("after_halt");
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
